// File: rtl/pll_clken_gen.sv
// pll_clken_gen: PLL-style clock-enable generator.
// A serial config chain loads per-channel dividers. A lock FSM waits LOCK_CYCLES
// good cycles before releasing the channel counters. Each counter emits one
// clken pulse every div+1 cycles. Bypass forces all enables and lock high.
module pll_clken_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resetb,
    input  logic              bypass,
    input  logic              cfg_shift,
    input  logic              cfg_sdi,
    input  logic              cfg_latch,
    output logic              cfg_sdo,
    output logic [NUM_CH-1:0] clken,
    output logic              lock
);

    localparam int SR_W = NUM_CH * DIV_W;
    localparam int LC_W = 16;
    localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);

    typedef enum logic {RELOCK = 1'b0, LOCKED = 1'b1} state_t;

    logic [SR_W-1:0]                sh_q, sh_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   div_q, div_d;
    state_t                         state_q, state_d;
    logic [LC_W-1:0]                lock_cnt_q, lock_cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]              clken_q, clken_d;

    // Config chain: the latch samples the pre-shift contents, so the shift runs independently.
    always_comb begin
        sh_d  = sh_q;
        div_d = div_q;
        if (cfg_latch) begin
            div_d = sh_q;
        end
        if (cfg_shift) begin
            sh_d = (sh_q << 1) | SR_W'(cfg_sdi);
        end
    end

    // Lock FSM next state: any latch or resetb low restarts the lock delay.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (!resetb || cfg_latch) begin
            state_d    = RELOCK;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                RELOCK: begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = LOCKED;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LC_W'(1);
                    end
                end
                LOCKED: begin
                    state_d = LOCKED;
                end
                default: begin
                    state_d = RELOCK;
                end
            endcase
        end
    end

    // Channel counters: start at 0 on the first LOCKED cycle, wrap when they hit div.
    // The enable is registered from the next count so it lines up with cnt==div.
    always_comb begin
        cnt_d   = '0;
        clken_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (state_d == LOCKED) begin
                if (state_q == LOCKED && cnt_q[k] != div_q[k]) begin
                    cnt_d[k] = cnt_q[k] + DIV_W'(1);
                end
                clken_d[k] = (cnt_d[k] == div_q[k]);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q       <= '0;
            div_q      <= {NUM_CH{DIV_W'(DEFAULT_DIV)}};
            state_q    <= RELOCK;
            lock_cnt_q <= '0;
            cnt_q      <= '0;
            clken_q    <= '0;
        end else begin
            sh_q       <= sh_d;
            div_q      <= div_d;
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            cnt_q      <= cnt_d;
            clken_q    <= clken_d;
        end
    end

    assign cfg_sdo = sh_q[SR_W-1];
    assign clken   = bypass ? {NUM_CH{1'b1}} : clken_q;
    assign lock    = bypass | (state_q == LOCKED);

endmodule

// File: tb/tb_pll_clken_gen.sv
// Testbench for pll_clken_gen: directed scenarios plus randomized episodes,
// checked every cycle against a count-based behavioural model.
module tb_pll_clken_gen;

    localparam int NC   = 2;
    localparam int DW   = 8;
    localparam int LC   = 16;
    localparam int DDIV = 3;
    localparam int SR_W = NC * DW;

    logic          clk = 1'b0;
    logic          reset, resetb, bypass, cfg_shift, cfg_sdi, cfg_latch;
    logic          cfg_sdo, lock;
    logic [NC-1:0] clken;

    int errors = 0;
    int checks = 0;

    // Behavioural model: the config word, divider values, the run of good cycles
    // (resetb high, no latch) and the index of the current LOCKED cycle.
    logic [SR_W-1:0] m_sh;
    int              m_div [NC];
    int              m_good;
    int              m_idx;

    always #5 clk = ~clk;

    pll_clken_gen #(
        .NUM_CH(NC), .DIV_W(DW), .LOCK_CYCLES(LC), .DEFAULT_DIV(DDIV)
    ) dut (
        .clk(clk), .reset(reset), .resetb(resetb), .bypass(bypass),
        .cfg_shift(cfg_shift), .cfg_sdi(cfg_sdi), .cfg_latch(cfg_latch),
        .cfg_sdo(cfg_sdo), .clken(clken), .lock(lock)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] exp_clken();
        logic [NC-1:0] e;
        e = '0;
        if (m_idx >= 0) begin
            for (int k = 0; k < NC; k++) begin
                e[k] = ((m_idx % (m_div[k] + 1)) == m_div[k]);
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_sh   = '0;
        for (int k = 0; k < NC; k++) m_div[k] = DDIV;
        m_good = 0;
        m_idx  = -1;
    endtask

    // One clock edge of the model, using the inputs held during that cycle.
    task automatic model_update();
        if (reset) begin
            model_reset();
        end else begin
            if (cfg_latch) begin
                for (int k = 0; k < NC; k++) m_div[k] = int'(m_sh[k*DW +: DW]);
            end
            if (cfg_shift) m_sh = {m_sh[SR_W-2:0], cfg_sdi};
            if (resetb && !cfg_latch) begin
                m_good++;
                m_idx = (m_good >= LC) ? (m_good - LC) : -1;
            end else begin
                m_good = 0;
                m_idx  = -1;
            end
        end
    endtask

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        chk("lock",  32'(lock),    32'(bypass | (m_idx >= 0)));
        chk("clken", 32'(clken),   32'(bypass ? {NC{1'b1}} : exp_clken()));
        chk("sdo",   32'(cfg_sdo), 32'(m_sh[SR_W-1]));
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic set_idle();
        resetb = 1'b1; bypass = 1'b0; cfg_shift = 1'b0; cfg_sdi = 1'b0; cfg_latch = 1'b0;
    endtask

    task automatic shift_word(input logic [SR_W-1:0] w, input bit gaps);
        for (int i = SR_W - 1; i >= 0; i--) begin
            while (gaps && $urandom_range(0, 4) == 0) begin
                cfg_shift = 1'b0; cfg_sdi = 1'($urandom);
                tick();
            end
            cfg_shift = 1'b1; cfg_sdi = w[i];
            tick();
        end
        cfg_shift = 1'b0;
    endtask

    initial begin
        logic [SR_W-1:0] w;
        int              len;
        bit              quiet;

        set_idle();
        reset = 1'b1;
        model_reset();
        repeat (3) tick();
        chk("rst_lock", 32'(lock), 0);
        chk("rst_clken", 32'(clken), 0);

        // Defaults after reset release: lock from cycle 16, pulses at 19, 23.
        reset = 1'b0;
        repeat (15) tick();
        chk("def_lock15", 32'(lock), 0);
        tick();
        chk("def_lock16", 32'(lock), 1);
        repeat (2) tick();
        chk("def_clk18", 32'(clken), 0);
        tick();
        chk("def_clk19", 32'(clken), 3);
        tick();
        chk("def_clk20", 32'(clken), 0);
        repeat (3) tick();
        chk("def_clk23", 32'(clken), 3);

        // Load ch1=5, ch0=0 and relock.
        shift_word(16'h0500, 1'b0);
        cfg_latch = 1'b1;
        tick();
        cfg_latch = 1'b0;
        chk("ld_lock0", 32'(lock), 0);
        repeat (15) tick();
        chk("ld_lock15", 32'(lock), 0);
        tick();
        chk("ld_lock16", 32'(lock), 1);
        chk("ld_clk_i0", 32'(clken), 1);
        repeat (5) tick();
        chk("ld_clk_i5", 32'(clken), 3);
        repeat (20) tick();

        // resetb low for 5 cycles while locked.
        resetb = 1'b0;
        tick();
        chk("rb_lock", 32'(lock), 0);
        chk("rb_clken", 32'(clken), 0);
        repeat (4) tick();
        resetb = 1'b1;
        repeat (15) tick();
        chk("rb_lock15", 32'(lock), 0);
        tick();
        chk("rb_lock16", 32'(lock), 1);
        chk("rb_clk_i0", 32'(clken), 1);

        // Bypass during relock.
        cfg_latch = 1'b1;
        tick();
        cfg_latch = 1'b0;
        bypass = 1'b1;
        #1;
        chk("bp_lock", 32'(lock), 1);
        chk("bp_clken", 32'(clken), 3);
        repeat (10) tick();
        bypass = 1'b0;
        #1;
        chk("bp_drop_lock", 32'(lock), 0);
        repeat (5) tick();
        chk("bp_lock5", 32'(lock), 0);
        tick();
        chk("bp_lock6", 32'(lock), 1);

        // Latch together with shift: divider takes 0x0203, not 0x0407.
        shift_word(16'h0203, 1'b0);
        cfg_latch = 1'b1; cfg_shift = 1'b1; cfg_sdi = 1'b1;
        tick();
        set_idle();
        repeat (16) tick();
        chk("ls_lock", 32'(lock), 1);
        repeat (3) tick();
        chk("ls_clk_i3", 32'(clken), 1);
        // Second latch mid-relock restarts the count.
        cfg_latch = 1'b1;
        tick();
        cfg_latch = 1'b0;
        repeat (8) tick();
        cfg_latch = 1'b1;
        tick();
        cfg_latch = 1'b0;
        repeat (15) tick();
        chk("l2_lock15", 32'(lock), 0);
        tick();
        chk("l2_lock16", 32'(lock), 1);

        // Randomized episodes; episode 0 uses the extreme dividers 255 and 0.
        for (int ep = 0; ep < 24; ep++) begin
            quiet = (ep == 0);
            for (int k = 0; k < NC; k++) begin
                if (quiet) w[k*DW +: DW] = (k == NC - 1) ? 8'hFF : 8'h00;
                else if ($urandom_range(0, 3) != 0) w[k*DW +: DW] = 8'($urandom_range(0, 9));
                else w[k*DW +: DW] = 8'($urandom);
            end
            shift_word(w, !quiet);
            cfg_latch = 1'b1;
            if (!quiet && $urandom_range(0, 3) == 0) begin
                cfg_shift = 1'b1; cfg_sdi = 1'($urandom);
            end
            tick();
            set_idle();
            len = quiet ? 600 : int'($urandom_range(40, 300));
            for (int c = 0; c < len; c++) begin
                if (!quiet) begin
                    resetb    = ($urandom_range(0, 99) != 0);
                    cfg_latch = ($urandom_range(0, 149) == 0);
                    cfg_shift = ($urandom_range(0, 3) == 0);
                    cfg_sdi   = 1'($urandom);
                    if ($urandom_range(0, 49) == 0) bypass = ~bypass;
                end
                tick();
            end
            set_idle();
        end

        // Asynchronous reset mid-shift while locked.
        set_idle();
        repeat (20) tick();
        cfg_shift = 1'b1; cfg_sdi = 1'b1;
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_lock", 32'(lock), 0);
        chk("ar_clken", 32'(clken), 0);
        chk("ar_sdo", 32'(cfg_sdo), 0);
        model_reset();
        set_idle();
        tick();
        reset = 1'b0;
        repeat (16) tick();
        chk("ar_lock16", 32'(lock), 1);
        repeat (3) tick();
        chk("ar_clk19", 32'(clken), 3);
        repeat (4) tick();
        chk("ar_clk23", 32'(clken), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
